wb_commit_queue: RTL
====================

Name: wb_commit_queue

Overview:
- Writer side of the register-file write port; sits between execute/memory result producers and the register file.
- Accepts results from an ALU producer and a load producer over valid/ready handshakes and buffers them in order in a small FIFO.
- Drains one entry per cycle into the register file as we/waddr/wdata/pc.
- Provides an associative bypass lookup of pending, not-yet-committed writes for the decode stage.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 5, register address width
DW, 32, data width
PCW, 32, pc width carried with each entry for commit tracing

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
alu_rd  in  AW  ALU destination register
alu_data  in  DW  ALU result
alu_pc  in  PCW  pc of the ALU instruction
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted this cycle when ld_valid=1
ld_rd  in  AW  load destination register
ld_data  in  DW  load result
ld_pc  in  PCW  pc of the load instruction
commit_hold  in  1  when 1, no dequeue this cycle
rf_we  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
rf_wdata  out  DW  register-file write data
rf_pc  out  PCW  pc of the committing entry
q_addr  in  AW  bypass lookup address
q_hit  out  1  a pending entry targets q_addr
q_data  out  DW  data of the youngest matching entry
pending  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular FIFO of {rd, data, pc}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Reset (async): pointers and count = 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_pc=0, alu_ready=0, ld_ready=0, q_hit=0, q_data=0.
  - Reset mid-operation discards all pending entries.
- Enqueue: at most one per cycle.
  - Load has priority: ld_ready = !full.
  - alu_ready = !full && !ld_valid.
  - full means count==DEPTH; readiness depends only on full, with no pass-through from a same-cycle dequeue.
- x0 filter: a handshaken entry with rd==0 completes the handshake but is not stored. count is unchanged and it never commits.
- Dequeue: rf_we = (count!=0) && !commit_hold, combinationally from the head entry.
  - rf_waddr/rf_wdata/rf_pc show the head entry whenever count!=0, and 0 when empty.
  - The register file samples on negedge within the same cycle; rd_ptr advances on the following posedge when rf_we=1.
- Latency: an entry enqueued at posedge N into an empty queue gives rf_we=1 during cycle N..N+1 and pops at posedge N+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Empty: rf_we=0, no pop. Full: both producer readies are 0, dequeue proceeds normally.
- Ordering: commit order equals acceptance order, so a load accepted before a later ALU result commits first.
- Bypass (combinational): q_hit=1 if any valid entry has rd==q_addr and q_addr!=0.
  - q_data is the data of the youngest such entry (closest to wr_ptr); 0 when no hit.
  - The head entry counts while it is still valid, including during its commit cycle.
- pending = count.

Optional Feature:
- Macro COMMIT_TRACE_EN.
  - Defined: on every negedge with rf_we=1, simulation prints "pc = %h: x%d = %h" with rf_pc, rf_waddr, rf_wdata.
  - Undefined: no display statements; logic identical.

Decomposition:
- Shared package/header holds:
  - ADDR_BUS-style width macros for pc.
  - The register-address width.
  - The commit entry typedef {rd, data, pc}.
- One natural sub-module: wb_bypass_match, the youngest-match priority search over the entry array.

Test Plan:
1. Reset, then ALU rd=5 data=0x11 pc=0x0 -> rf_we=1 next cycle, waddr=5, wdata=0x11; pending returns to 0.
2. ld_valid and alu_valid together (ld rd=3 data=0xAA, alu rd=4 data=0xBB) -> ld accepted, alu_ready=0 that cycle, alu accepted next; commits x3 then x4.
3. commit_hold=1 with 4 ALU writes -> pending=4, alu_ready=0, 5th held; release -> 4 commits in order on consecutive cycles.
4. Enqueue x7=0x1 then x7=0x2, query q_addr=7 -> q_hit=1, q_data=0x2; q_addr=0 -> q_hit=0.
5. ALU rd=0 data=0xFF -> handshake completes, pending stays 0, no rf_we.
6. Assert rst with 3 pending -> rf_we=0 immediately, pending=0; post-reset writes commit normally.

Source files
------------

// File: rtl/wb_commit_queue_pkg.sv
// Shared widths and the commit entry type for the register-file write queue.
// WB_PC_BITS may be overridden on the command line to widen the traced pc.
`ifndef WB_PC_BITS
`define WB_PC_BITS 32
`endif

package wb_commit_queue_pkg;

    localparam int WB_AW  = 5;
    localparam int WB_DW  = 32;
    localparam int WB_PCW = `WB_PC_BITS;

    typedef struct packed {
        logic [WB_AW-1:0]  rd;
        logic [WB_DW-1:0]  data;
        logic [WB_PCW-1:0] pc;
    } wb_entry_t;

    // x0 is hardwired to zero, so writes to it are never kept
    function automatic logic rd_live(input logic [WB_AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_commit_queue_if.sv
// Producer, commit and bypass signals of the write-back commit queue.
// slave is the queue side; master is the side driving producers and lookups.
interface wb_commit_queue_if
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int PCW   = WB_PCW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic           alu_valid;
    logic           alu_ready;
    logic [AW-1:0]  alu_rd;
    logic [DW-1:0]  alu_data;
    logic [PCW-1:0] alu_pc;

    logic           ld_valid;
    logic           ld_ready;
    logic [AW-1:0]  ld_rd;
    logic [DW-1:0]  ld_data;
    logic [PCW-1:0] ld_pc;

    logic           commit_hold;
    logic           rf_we;
    logic [AW-1:0]  rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic [PCW-1:0] rf_pc;

    logic [AW-1:0]  q_addr;
    logic           q_hit;
    logic [DW-1:0]  q_data;
    logic [CW-1:0]  pending;

    modport slave (
        input  alu_valid, alu_rd, alu_data, alu_pc,
        input  ld_valid, ld_rd, ld_data, ld_pc,
        input  commit_hold, q_addr,
        output alu_ready, ld_ready,
        output rf_we, rf_waddr, rf_wdata, rf_pc,
        output q_hit, q_data, pending
    );

    modport master (
        output alu_valid, alu_rd, alu_data, alu_pc,
        output ld_valid, ld_rd, ld_data, ld_pc,
        output commit_hold, q_addr,
        input  alu_ready, ld_ready,
        input  rf_we, rf_waddr, rf_wdata, rf_pc,
        input  q_hit, q_data, pending
    );

endinterface

// File: rtl/wb_commit_queue_bypass.sv
// Youngest-match search over the live FIFO entries for decode bypass.
// Entries are walked oldest to youngest so the last match wins.
module wb_bypass_match
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic [AW-1:0] i_rd   [DEPTH],
    input  logic [DW-1:0] i_data [DEPTH],
    input  logic [PW-1:0] i_rd_ptr,
    input  logic [CW-1:0] i_count,
    input  logic [AW-1:0] i_q_addr,
    output logic          o_hit,
    output logic [DW-1:0] o_data
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_rd_ptr + PW'(k);
            if ((CW'(k) < i_count) &&
                (i_q_addr != '0) &&
                (i_rd[w_idx] == i_q_addr)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order commit queue in front of the register-file write port.
// Define COMMIT_TRACE_EN to print each commit on the register-file edge.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int PCW   = WB_PCW
) (
    input logic            clk,
    input logic            rst,
    wb_commit_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_live;

    logic          w_full;
    logic          w_empty;
    logic          w_ld_rdy;
    logic          w_alu_rdy;
    logic          w_ld_acc;
    logic          w_alu_acc;
    logic          w_push;
    logic          w_pop;
    wb_entry_t     w_in;
    wb_entry_t     w_head;
    logic [AW-1:0] w_rd   [DEPTH];
    logic [DW-1:0] w_data [DEPTH];

    assign w_full  = r_count == CW'(DEPTH);
    assign w_empty = r_count == '0;

    // Readiness is held low until the first edge after reset releases
    assign w_ld_rdy  = r_live && !w_full;
    assign w_alu_rdy = r_live && !w_full && !bus.ld_valid;
    assign w_ld_acc  = bus.ld_valid && w_ld_rdy;
    assign w_alu_acc = bus.alu_valid && w_alu_rdy;

    always_comb begin
        w_in = '0;
        unique case (1'b1)
            w_ld_acc: begin
                w_in.rd   = bus.ld_rd;
                w_in.data = bus.ld_data;
                w_in.pc   = bus.ld_pc;
            end
            w_alu_acc: begin
                w_in.rd   = bus.alu_rd;
                w_in.data = bus.alu_data;
                w_in.pc   = bus.alu_pc;
            end
            default: ;
        endcase
    end

    assign w_push = (w_ld_acc || w_alu_acc) && rd_live(w_in.rd);
    assign w_head = r_mem[r_rd_ptr];
    assign w_pop  = !w_empty && !bus.commit_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_in;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_rd[g]   = r_mem[g].rd;
        assign w_data[g] = r_mem[g].data;
    end

    wb_bypass_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_bypass (
        .i_rd     (w_rd),
        .i_data   (w_data),
        .i_rd_ptr (r_rd_ptr),
        .i_count  (r_count),
        .i_q_addr (bus.q_addr),
        .o_hit    (bus.q_hit),
        .o_data   (bus.q_data)
    );

    assign bus.alu_ready = w_alu_rdy;
    assign bus.ld_ready  = w_ld_rdy;
    assign bus.rf_we     = w_pop;
    assign bus.rf_waddr  = w_empty ? '0 : w_head.rd;
    assign bus.rf_wdata  = w_empty ? '0 : w_head.data;
    assign bus.rf_pc     = w_empty ? '0 : w_head.pc;
    assign bus.pending   = r_count;

`ifdef COMMIT_TRACE_EN
    always @(negedge clk) begin
        if (bus.rf_we)
            $display("pc = %h: x%d = %h",
                     bus.rf_pc, bus.rf_waddr, bus.rf_wdata);
    end
`else
`endif

endmodule
